// File: rtl/mesh_result_drainer.sv
`default_nettype none
// ============================================================================
// Module   : mesh_result_drainer
// Purpose  : Read-side master for the systolic mesh result SRAM. Once the
//            mesh has finished collecting, it walks the ROWS x COLS result
//            matrix in row-major order. For each element it issues one read
//            at the tile-major unified address, waits for the response, and
//            presents the element on a valid/ready stream with row/col tags.
// Ports    : clk_i / rstn_i             clock, async active-low reset
//            start_i                    drain request (IDLE + complete only)
//            collection_complete_i      result SRAM fully written
//            mem_read_enable_o/addr_o   one-cycle read strobe and address
//            mem_read_data_i/valid_i    read response
//            m_valid_o/m_ready_i        output stream handshake
//            m_data_o/m_row_o/m_col_o   element value and position
//            m_last_o                   final element (ROWS-1, COLS-1)
//            busy_o / done_o            not-IDLE / completion pulse
//            timeout_o                  sticky read-timeout error
// Revision : 1.0  initial release
// ============================================================================
module mesh_result_drainer #(
  parameter  int TILE_SIZE      = 2,
  parameter  int DATA_WIDTH     = 32,
  parameter  int TILES_X        = 2,
  parameter  int TILES_Y        = 2,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int ROWS = TILE_SIZE * TILES_Y,
  localparam int COLS = TILE_SIZE * TILES_X,
  localparam int AW   = $clog2(TILE_SIZE * TILE_SIZE * TILES_X * TILES_Y),
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  collection_complete_i,
  output logic                  mem_read_enable_o,
  output logic [AW-1:0]         mem_read_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i,
  input  logic                  mem_read_valid_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [RW-1:0]         m_row_o,
  output logic [CW-1:0]         m_col_o,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o
);

  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_OUTPUT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [RW-1:0]         r_row;
  logic [CW-1:0]         r_col;
  logic [DATA_WIDTH-1:0] r_data;
  logic [TOW-1:0]        r_wait_cnt;
  logic                  r_timeout;

  logic w_accept;
  logic w_at_last;
  logic w_handshake;
  logic w_wait_expire;

  // Address translation. Constant divisors keep non-power-of-two tilings
  // correct; power-of-two sizes collapse to bit slicing in synthesis.
  int w_ty;
  int w_tx;
  int w_in;
  int w_lin;

  always_comb begin
    w_ty  = int'(r_row) / TILE_SIZE;
    w_tx  = int'(r_col) / TILE_SIZE;
    w_in  = (int'(r_row) % TILE_SIZE) * TILE_SIZE + (int'(r_col) % TILE_SIZE);
    w_lin = (w_ty * TILES_X + w_tx) * TILE_SIZE * TILE_SIZE + w_in;
  end

  assign mem_read_addr_o = AW'(w_lin);

  assign w_accept      = (r_state == S_IDLE) && start_i && collection_complete_i;
  assign w_at_last     = (r_row == RW'(ROWS - 1)) && (r_col == CW'(COLS - 1));
  assign w_handshake   = (r_state == S_OUTPUT) && m_ready_i;
  // The counter value on entry to a WAIT cycle equals the number of WAIT
  // cycles already spent, so the TIMEOUT_CYCLES-th silent cycle aborts.
  assign w_wait_expire = (r_state == S_WAIT) && !mem_read_valid_i &&
                         (r_wait_cnt == TOW'(TIMEOUT_CYCLES - 1));

  assign mem_read_enable_o = (r_state == S_ISSUE);
  assign m_valid_o         = (r_state == S_OUTPUT);
  assign m_data_o          = r_data;
  assign m_row_o           = r_row;
  assign m_col_o           = r_col;
  assign m_last_o          = (r_state == S_OUTPUT) && w_at_last;
  assign busy_o            = (r_state != S_IDLE);
  assign done_o            = (r_state == S_DONE);
  assign timeout_o         = r_timeout;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE:  w_state_nxt = mem_read_valid_i ? S_OUTPUT : S_WAIT;
      S_WAIT: begin
        if (mem_read_valid_i)   w_state_nxt = S_OUTPUT;
        else if (w_wait_expire) w_state_nxt = S_IDLE;
      end
      S_OUTPUT: if (m_ready_i) w_state_nxt = w_at_last ? S_DONE : S_ISSUE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_row      <= '0;
      r_col      <= '0;
      r_data     <= '0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_row     <= '0;
        r_col     <= '0;
        r_timeout <= 1'b0;
      end

      if (r_state == S_ISSUE) begin
        r_wait_cnt <= '0;
        if (mem_read_valid_i) r_data <= mem_read_data_i;
      end

      if (r_state == S_WAIT) begin
        if (mem_read_valid_i) begin
          r_data <= mem_read_data_i;
        end else begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (w_wait_expire) r_timeout <= 1'b1;
        end
      end

      // The last element leaves row/col parked at the final position.
      if (w_handshake && !w_at_last) begin
        if (r_col == CW'(COLS - 1)) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mesh_result_drainer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesh_result_drainer
// Purpose  : Directed self-checking bench for mesh_result_drainer with a
//            2x2 mesh of 2x2 tiles. A small responder returns addr*3 with
//            latency 0 or 1 and can be told to ignore the read of addr 4.
// Revision : 1.0  initial release
// ============================================================================
module tb_mesh_result_drainer;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0;
  logic        collection_complete_i = 1'b1;
  logic        mem_read_enable_o;
  logic [3:0]  mem_read_addr_o;
  logic [31:0] mem_read_data_i;
  logic        mem_read_valid_i;
  logic        m_valid_o;
  logic        m_ready_i = 1'b1;
  logic [31:0] m_data_o;
  logic [1:0]  m_row_o;
  logic [1:0]  m_col_o;
  logic        m_last_o;
  logic        busy_o;
  logic        done_o;
  logic        timeout_o;

  always #5 clk_i = ~clk_i;

  mesh_result_drainer #(
    .TILE_SIZE(2), .DATA_WIDTH(32), .TILES_X(2), .TILES_Y(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_i                 (clk_i),
    .rstn_i                (rstn_i),
    .start_i               (start_i),
    .collection_complete_i (collection_complete_i),
    .mem_read_enable_o     (mem_read_enable_o),
    .mem_read_addr_o       (mem_read_addr_o),
    .mem_read_data_i       (mem_read_data_i),
    .mem_read_valid_i      (mem_read_valid_i),
    .m_valid_o             (m_valid_o),
    .m_ready_i             (m_ready_i),
    .m_data_o              (m_data_o),
    .m_row_o               (m_row_o),
    .m_col_o               (m_col_o),
    .m_last_o              (m_last_o),
    .busy_o                (busy_o),
    .done_o                (done_o),
    .timeout_o             (timeout_o)
  );

  // Responder: latency 0 (combinational) or 1 (registered); optional drop of addr 4.
  logic        lat0 = 1'b0;
  logic        kill = 1'b0;
  logic        r_v  = 1'b0;
  logic [31:0] r_d  = '0;

  always @(posedge clk_i) begin
    r_v <= mem_read_enable_o && !(kill && (mem_read_addr_o == 4'd4));
    r_d <= 32'(mem_read_addr_o) * 32'd3;
  end

  assign mem_read_valid_i = lat0 ? mem_read_enable_o : r_v;
  assign mem_read_data_i  = lat0 ? 32'(mem_read_addr_o) * 32'd3 : r_d;

  // Hand-computed tile-major address for each row-major element.
  int exp_addr [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

  int n_tests = 0;
  int n_fail  = 0;

  int n_out, n_rd, n_done, done_cyc, first_rd_cyc, first_v_cyc, to_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {mem_read_enable_o, mem_read_addr_o, m_valid_o, m_data_o, m_row_o,
                m_col_o, m_last_o, busy_o, done_o, timeout_o}, 64'd0);
  endtask

  // Starts a drain and follows it cycle by cycle until done, timeout,
  // the reset abort point, or the cycle budget. Samples 1 time unit after
  // each falling edge, right after choosing m_ready_i for the next edge.
  task automatic drain(input int rdy_pct, input int pulse_at, input int drop_cc_at,
                       input int abort_elem);
    logic        held_v;
    logic [31:0] h_d;
    logic [1:0]  h_r, h_c;
    logic        h_l;
    int          c;
    n_out = 0; n_rd = 0; n_done = 0;
    done_cyc = -1; first_rd_cyc = -1; first_v_cyc = -1; to_cyc = -1;
    held_v = 1'b0; h_d = '0; h_r = '0; h_c = '0; h_l = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1;
    collection_complete_i = 1'b1;
    c = 0;
    while (c < 1000) begin
      @(negedge clk_i);
      c++;
      start_i = (c == pulse_at);
      if (c == drop_cc_at) collection_complete_i = 1'b0;
      m_ready_i = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (c == 1) check("timeout_cleared_on_start", timeout_o, 0);
      if (mem_read_enable_o) begin
        if (first_rd_cyc < 0) first_rd_cyc = c;
        if (n_rd < 16) check("read_addr", mem_read_addr_o, exp_addr[n_rd]);
        n_rd++;
      end
      if (m_valid_o) begin
        if (first_v_cyc < 0) first_v_cyc = c;
        if (abort_elem == n_out) begin
          rstn_i = 1'b0;
          #1;
          check_reset_vals("async_reset_in_output");
          break;
        end
        if (held_v) check("hold_stable", {m_data_o, m_row_o, m_col_o, m_last_o},
                          {h_d, h_r, h_c, h_l});
        if (m_ready_i) begin
          check("elem_data", m_data_o, exp_addr[n_out % 16] * 3);
          check("elem_rowcol", {m_row_o, m_col_o}, {2'(n_out / 4), 2'(n_out % 4)});
          check("elem_last", m_last_o, (n_out == 15));
          n_out++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          h_d = m_data_o; h_r = m_row_o; h_c = m_col_o; h_l = m_last_o;
        end
      end
      if (done_o) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (timeout_o) to_cyc = c;
      if (done_o || timeout_o) break;
    end
    if (c >= 1000) check("drain_cycle_budget", 1, 0);
    start_i = 1'b0;
    m_ready_i = 1'b1;
    collection_complete_i = 1'b1;
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clk_i);
    #1;
    check(tag, {busy_o, done_o, m_valid_o, mem_read_enable_o}, 0);
  endtask

  initial begin
    // Reset values, before any clock edge.
    #1;
    check_reset_vals("reset_values");
    @(negedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // 1) Latency 1, sink always ready: 3 cycles per element + DONE.
    lat0 = 1'b0;
    drain(100, -1, -1, -1);
    check("l1_first_strobe_cycle", first_rd_cyc, 1);
    check("l1_first_valid_cycle", first_v_cyc, 3);
    check("l1_elements", n_out, 16);
    check("l1_reads", n_rd, 16);
    check("l1_done_count", n_done, 1);
    check("l1_done_cycle", done_cyc, 49);
    check_idle_after("l1_idle_after_done");

    // 2) Random backpressure about 50%: same sequence, held while stalled.
    drain(50, -1, -1, -1);
    check("bp_elements", n_out, 16);
    check("bp_reads", n_rd, 16);
    check("bp_done_count", n_done, 1);
    check_idle_after("bp_idle_after_done");

    // 3) Latency 0: one element every 2 cycles.
    lat0 = 1'b1;
    drain(100, -1, -1, -1);
    check("l0_first_valid_cycle", first_v_cyc, 2);
    check("l0_elements", n_out, 16);
    check("l0_done_cycle", done_cyc, 33);
    lat0 = 1'b0;
    check_idle_after("l0_idle_after_done");

    // 4) Read of addr 4 never answered: strobe in cycle 7, WAIT from 8,
    //    timeout visible in cycle 72.
    kill = 1'b1;
    drain(100, -1, -1, -1);
    check("to_cycle", to_cyc, 72);
    check("to_elements", n_out, 2);
    check("to_reads", n_rd, 3);
    check("to_no_done", n_done, 0);
    check("to_busy_low", busy_o, 0);
    @(negedge clk_i);
    #1;
    check("to_sticky", {timeout_o, busy_o, done_o}, 3'b100);
    kill = 1'b0;
    drain(100, -1, -1, -1);
    check("to_restart_elements", n_out, 16);
    check("to_restart_done_cycle", done_cyc, 49);
    check_idle_after("to_restart_idle");

    // 5) Start without collection complete: nothing happens.
    @(negedge clk_i);
    collection_complete_i = 1'b0;
    start_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      #1;
      check("cc0_no_activity", {busy_o, mem_read_enable_o}, 2'b00);
    end
    start_i = 1'b0;
    collection_complete_i = 1'b1;

    //    Start pulsed mid-drain and collection_complete dropped mid-drain.
    drain(100, 10, 5, -1);
    check("midstart_elements", n_out, 16);
    check("midstart_reads", n_rd, 16);
    check("midstart_done_count", n_done, 1);
    check("midstart_done_cycle", done_cyc, 49);
    check_idle_after("midstart_idle");

    // 6) Async reset while presenting element 5, then restart at (0,0).
    drain(100, -1, -1, 5);
    check("rst_elements_before", n_out, 5);
    @(negedge clk_i);
    #1;
    check_reset_vals("reset_held");
    rstn_i = 1'b1;
    drain(100, -1, -1, -1);
    check("rst_restart_first_strobe", first_rd_cyc, 1);
    check("rst_restart_elements", n_out, 16);
    check("rst_restart_done_cycle", done_cyc, 49);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mesh_result_drainer.md
# mesh_result_drainer

Read-side master for the systolic mesh result SRAM. After the mesh reports collection complete, the block walks the full result matrix in row-major order. For each element it translates the matrix (row, col) position into the mesh's unified tile-major read address, issues one read, and waits for the response. It then presents the element on a valid/ready output stream with row/col tags and an end-of-matrix marker, and sits between the mesh read port and the host/DMA result sink.

## Interface
- TILE_SIZE, 2, tile dimension N (N x N PEs per tile)
- DATA_WIDTH, 32, element width
- TILES_X, 2, tiles per mesh row (column direction)
- TILES_Y, 2, tiles per mesh column (row direction)
- TIMEOUT_CYCLES, 64, maximum cycles to wait for a read response; must be at least 2
- Derived: ROWS=TILE_SIZE*TILES_Y, COLS=TILE_SIZE*TILES_X, AW=$clog2(TILE_SIZE*TILE_SIZE*TILES_X*TILES_Y)

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- start_i  in  1  drain request; accepted only in IDLE with collection_complete_i=1
- collection_complete_i  in  1  mesh result SRAM fully written
- mem_read_enable_o  out  1  read strobe to mesh
- mem_read_addr_o  out  AW  mesh unified read address
- mem_read_data_i  in  DATA_WIDTH  mesh read data
- mem_read_valid_i  in  1  mesh read data valid
- m_valid_o  out  1  output element valid
- m_ready_i  in  1  sink ready
- m_data_o  out  DATA_WIDTH  element value
- m_row_o  out  $clog2(ROWS)  element row
- m_col_o  out  $clog2(COLS)  element col
- m_last_o  out  1  high with the final element (ROWS-1, COLS-1)
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse on normal completion
- timeout_o  out  1  sticky error flag; cleared by the next accepted start

## Operation
- States: IDLE, ISSUE, WAIT, OUTPUT, DONE.
- IDLE: accepts start_i when collection_complete_i=1, then clears row/col to 0, clears timeout_o, and goes to ISSUE. A start with collection_complete_i=0 is ignored.
- ISSUE: mem_read_enable_o=1 for exactly this cycle, with mem_read_addr_o valid.
  - If mem_read_valid_i=1 in the same cycle (combinational responder), data is captured and the next state is OUTPUT.
  - Otherwise the next state is WAIT.
- WAIT: the wait counter increments each cycle.
  - When mem_read_valid_i=1, capture mem_read_data_i and go to OUTPUT.
  - When the counter reaches TIMEOUT_CYCLES with no response, set timeout_o and go to IDLE. The drain is aborted and done_o is not pulsed.
- OUTPUT: m_valid_o=1, and data, row, col and last are held stable until m_ready_i=1.
  - On handshake with m_last_o=1, go to DONE.
  - On any other handshake, advance col. At col=COLS-1, col wraps to 0 and row increments. Then go to ISSUE.
- DONE: done_o=1 for one cycle, then IDLE.
- start_i is ignored whenever busy_o=1. mem_read_valid_i is ignored in IDLE, OUTPUT and DONE.
- Address translation, row-major within each tile and tiles row-major across the mesh:
  - ty=row/TILE_SIZE, tx=col/TILE_SIZE
  - in=(row%TILE_SIZE)*TILE_SIZE + col%TILE_SIZE
  - addr=(ty*TILES_X+tx)*TILE_SIZE*TILE_SIZE + in, truncated to AW bits
  - Power-of-two parameters reduce to bit slicing. Non-power-of-two parameters must still be correct, using constant divide/modulo or incremental counters.
- Exactly one read is outstanding at a time, and no new read is issued until the previous element has been handed off.

## Timing
- Reset (asynchronous): state=IDLE. mem_read_enable_o=0, mem_read_addr_o=0, m_valid_o=0, m_data_o=0, m_row_o=0, m_col_o=0, m_last_o=0, busy_o=0, done_o=0, timeout_o=0, wait counter=0.
- Start accepted at edge k: ISSUE during cycle k+1, so the first mem_read_enable_o is high one cycle after acceptance.
- With a responder latency of L cycles after the strobe (L>=1), m_valid_o rises L+1 cycles after the strobe. With L=0, it rises one cycle after the strobe.
- Best-case throughput with L=0 and m_ready_i tied high is one element per 2 cycles. A full matrix takes 2*ROWS*COLS cycles plus 1 for DONE.
- m_ready_i may be low indefinitely. There is no timeout in OUTPUT.
- Reset asserted mid-drain returns the block to IDLE immediately, drops m_valid_o and does not pulse done_o.
- collection_complete_i falling mid-drain has no effect. It is sampled only at start.

## Test plan
- TILE_SIZE=2, TILES 2x2, responder L=1 with data=addr*3, m_ready_i=1, start: addresses issued in order 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15. (1,2) yields addr 6, data 18. (3,3) yields addr 15, data 45 with m_last_o=1. done_o pulses once after 32+ cycles.
- Random m_ready_i backpressure (about 50%): the output sequence is identical to the first test, and m_data/row/col/last are stable while m_valid_o=1 and m_ready_i=0.
- Responder L=0 (combinational valid): no WAIT cycles, one element every 2 cycles, 16 elements in 32 cycles.
- Responder never answers the third read (addr 4): timeout_o rises 64 cycles after entering WAIT, the block returns to IDLE with busy_o=0 and done_o=0. A later start clears timeout_o and restarts at (0,0).
- start_i with collection_complete_i=0 produces no reads and busy_o stays 0. start_i pulsed during a drain is ignored and exactly 16 elements are output.
- rstn_i asserted while in OUTPUT at element 5: all outputs return to their reset values asynchronously. After release plus a start, the drain begins again at (0,0) with addr 0.
